// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the EX/MEM halt-drain state encoding.
package cpu_pkg;

    localparam int WORD_W  = 16;
    localparam int RADDR_W = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ex_mem_state_t;

endpackage

// File: rtl/ex_mem_pipe_dff.sv
// pipe_dff: parameterised-width pipeline register.
// It has an async active-low reset, a synchronous clear that beats enable, and an enable.
module pipe_dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Register with clear priority over enable; holds when neither is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX/MEM pipeline register with stall/flush, forwarding bus,
// load-use indication and HALT drain tracking.
// Optional macro EX_MEM_PERF_EN adds a saturating stall_cnt output.
module ex_mem_pipe #(
    parameter int WORD_W  = cpu_pkg::WORD_W,
    parameter int RADDR_W = cpu_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    input  logic [WORD_W-1:0]  ex_result,
    input  logic [WORD_W-1:0]  ex_store_data,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               ex_reg_write,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic               ex_halt,
    input  logic               stall,
    input  logic               flush,
    output logic               mem_valid,
    output logic [WORD_W-1:0]  mem_result,
    output logic [WORD_W-1:0]  mem_store_data,
    output logic [RADDR_W-1:0] mem_rd,
    output logic               mem_reg_write,
    output logic               mem_mem_read,
    output logic               mem_mem_write,
    output logic               fwd_en,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [WORD_W-1:0]  fwd_data,
    output logic               load_use,
`ifdef EX_MEM_PERF_EN
    output logic [WORD_W-1:0]  stall_cnt,
`endif
    output logic               halted
);

    import cpu_pkg::*;

    localparam int DATA_W = 2 * WORD_W + RADDR_W;

    ex_mem_state_t state;

    logic              accept;
    logic              data_en;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        ctrl_d;
    logic [3:0]        ctrl_q;

    // Only RUN admits new instructions; DRAIN and HALTED capture bubbles.
    always_comb begin
        accept  = (state == RUN) && ex_valid;
        data_en = !flush && !stall && (state != HALTED);
        data_d  = {ex_result, ex_store_data, ex_rd};
        ctrl_d  = {accept,
                   accept && ex_reg_write,
                   accept && ex_mem_read,
                   accept && ex_mem_write};
    end

    // Data fields simply hold on flush; only control needs clearing to form a bubble.
    pipe_dff #(.W(DATA_W)) u_data (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (data_en),
        .clr   (1'b0),
        .d     (data_d),
        .q     (data_q)
    );

    pipe_dff #(.W(4)) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!stall),
        .clr   (flush),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    // Unpack registered fields and derive forwarding / load-use from them.
    always_comb begin
        {mem_result, mem_store_data, mem_rd} = data_q;
        {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write} = ctrl_q;
        fwd_en   = mem_valid && mem_reg_write && !mem_mem_read;
        fwd_rd   = mem_rd;
        fwd_data = mem_result;
        load_use = mem_valid && mem_mem_read;
    end

    // HALT drain FSM: a flushed HALT is squashed, otherwise it retires on the next free edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!flush && !stall && ex_valid && ex_halt) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        state <= RUN;
                    end else if (!stall) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef EX_MEM_PERF_EN
    // Counts edges where a valid instruction is held by stall; saturates, frozen once halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((state != HALTED) && stall && !flush && mem_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed self-checking bench for ex_mem_pipe (both default and EX_MEM_PERF_EN builds).
module tb_ex_mem_pipe;

    localparam int WORD_W  = 16;
    localparam int RADDR_W = 3;

    logic               clk;
    logic               rst_n;
    logic               ex_valid;
    logic [WORD_W-1:0]  ex_result;
    logic [WORD_W-1:0]  ex_store_data;
    logic [RADDR_W-1:0] ex_rd;
    logic               ex_reg_write;
    logic               ex_mem_read;
    logic               ex_mem_write;
    logic               ex_halt;
    logic               stall;
    logic               flush;
    logic               mem_valid;
    logic [WORD_W-1:0]  mem_result;
    logic [WORD_W-1:0]  mem_store_data;
    logic [RADDR_W-1:0] mem_rd;
    logic               mem_reg_write;
    logic               mem_mem_read;
    logic               mem_mem_write;
    logic               fwd_en;
    logic [RADDR_W-1:0] fwd_rd;
    logic [WORD_W-1:0]  fwd_data;
    logic               load_use;
    logic               halted;
`ifdef EX_MEM_PERF_EN
    logic [WORD_W-1:0]  stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    ex_mem_pipe #(.WORD_W(WORD_W), .RADDR_W(RADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_result      (ex_result),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_halt        (ex_halt),
        .stall          (stall),
        .flush          (flush),
        .mem_valid      (mem_valid),
        .mem_result     (mem_result),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .fwd_en         (fwd_en),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
        .load_use       (load_use),
`ifdef EX_MEM_PERF_EN
        .stall_cnt      (stall_cnt),
`endif
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] res, input logic [15:0] sd,
                         input logic [2:0] rd, input logic rw, input logic mr,
                         input logic mw, input logic h);
        ex_valid      = v;
        ex_result     = res;
        ex_store_data = sd;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_halt       = h;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check("rst_valid", 32'(mem_valid), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_fwd_en", 32'(fwd_en), 32'h0);
        check("rst_result", 32'(mem_result), 32'h0);
        rst_n = 1'b1;

        // Capture and forward
        drive(1'b1, 16'h8000, 16'hAAAA, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("cap_valid", 32'(mem_valid), 32'h1);
        check("cap_result", 32'(mem_result), 32'h8000);
        check("cap_store", 32'(mem_store_data), 32'hAAAA);
        check("cap_fwd_en", 32'(fwd_en), 32'h1);
        check("cap_fwd_rd", 32'(fwd_rd), 32'h3);
        check("cap_fwd_data", 32'(fwd_data), 32'h8000);

        // Control bits qualified by ex_valid
        drive(1'b0, 16'h5555, 16'h0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        check("inv_valid", 32'(mem_valid), 32'h0);
        check("inv_ctrl", 32'({mem_reg_write, mem_mem_read, mem_mem_write}), 32'h0);
        check("inv_load_use", 32'(load_use), 32'h0);
        check("inv_fwd_en", 32'(fwd_en), 32'h0);

        // Load-use, then stall for two cycles with changed inputs
        drive(1'b1, 16'h0040, 16'h0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("ld_load_use", 32'(load_use), 32'h1);
        check("ld_fwd_en", 32'(fwd_en), 32'h0);
        check("ld_result", 32'(mem_result), 32'h0040);
        drive(1'b1, 16'h1111, 16'h0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stl_result", 32'(mem_result), 32'h0040);
            check("stl_rd", 32'(mem_rd), 32'h5);
            check("stl_load_use", 32'(load_use), 32'h1);
        end
        stall = 1'b0;

        // Flush beats stall
        drive(1'b1, 16'h0100, 16'hBEEF, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check("st_mem_write", 32'(mem_mem_write), 32'h1);
        stall = 1'b1;
        flush = 1'b1;
        step();
        check("fl_valid", 32'(mem_valid), 32'h0);
        check("fl_mem_write", 32'(mem_mem_write), 32'h0);
        check("fl_fwd_en", 32'(fwd_en), 32'h0);
        stall = 1'b0;
        flush = 1'b0;

        // HALT drain
        drive(1'b1, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("h_valid", 32'(mem_valid), 32'h1);
        check("h_halted0", 32'(halted), 32'h0);
        drive(1'b1, 16'h2222, 16'h3333, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check("h_mem_write", 32'(mem_mem_write), 32'h0);
        check("h_valid_drain", 32'(mem_valid), 32'h0);
        check("h_halted1", 32'(halted), 32'h1);
        drive(1'b1, 16'h4444, 16'h0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("h_ignored", 32'(mem_valid), 32'h0);
        check("h_fwd_en", 32'(fwd_en), 32'h0);
        check("h_sticky", 32'(halted), 32'h1);

        // Reset out of HALTED, then squash a HALT with flush
        rst_n = 1'b0;
        #1;
        check("h_rst_halted", 32'(halted), 32'h0);
        rst_n = 1'b1;
        drive(1'b1, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b1, 16'h9999, 16'h0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        check("sq_valid", 32'(mem_valid), 32'h0);
        check("sq_halted", 32'(halted), 32'h0);
        flush = 1'b0;
        drive(1'b1, 16'h1234, 16'h0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("sq_add_valid", 32'(mem_valid), 32'h1);
        check("sq_add_result", 32'(mem_result), 32'h1234);
        check("sq_add_fwd", 32'(fwd_en), 32'h1);
        step();
        check("sq_not_halted", 32'(halted), 32'h0);

        // Async reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(mem_valid), 32'h0);
        check("ar_result", 32'(mem_result), 32'h0);
        check("ar_reg_write", 32'(mem_reg_write), 32'h0);
        check("ar_fwd_en", 32'(fwd_en), 32'h0);
        step();
        rst_n = 1'b1;

`ifdef EX_MEM_PERF_EN
        check("pc_reset", 32'(stall_cnt), 32'h0);
        drive(1'b1, 16'h0007, 16'h0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("pc_three", 32'(stall_cnt), 32'h3);
        for (int i = 0; i < 65532; i++) step();
        check("pc_max", 32'(stall_cnt), 32'hFFFF);
        step();
        check("pc_saturate", 32'(stall_cnt), 32'hFFFF);
        stall = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
